// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the handshaked data memory.
//   size_t      - access size encoding (byte/half/word/dword)
//   state_t     - controller FSM state
//   size_mask   - low address bits that must be zero for an aligned access
//   byte_en     - byte-lane enables for a store of a given size and offset
//   load_extend - shift the addressed lane to bit 0 and sign/zero extend
// Helpers work on a 64-bit lane view; callers narrow to DATA_W.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] size_mask(input size_t sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byte_en(input size_t sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 8'h01 << off;
            SZ_H:    return 8'h03 << off;
            SZ_W:    return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] word, input size_t sz,
                                                input logic [2:0] off, input logic uns);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_B:    return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x DATA_W synchronous RAM with per-byte write enable and a
// READ_LAT-stage read pipeline. Read is read-first (old data on a same-cycle
// write). The array and pipeline have no reset.
// Ports:
//   clk      - clock, rising edge
//   i_we     - byte write enables (DATA_W/8)
//   i_addr   - word index
//   i_wdata  - lane-aligned write data
//   o_rdata  - read data, READ_LAT edges after i_addr was presented
module dmem_ram #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int IDX_W    = 10
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] i_we,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DATA_W-1:0] r_pipe [READ_LAT];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        r_pipe[0] <= r_mem[i_addr];
        for (int s = 1; s < READ_LAT; s++) begin
            r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_rdata = r_pipe[READ_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked data memory controller for the multicycle core.
// One access outstanding at a time: IDLE accepts, WAIT covers the read
// latency (one cycle for stores), RESP presents the response until taken.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the response payload is held stable while o_rsp_valid=1 and
// i_rsp_ready=0.
// Build option: define MISALIGN_TRAP_EN to fault misaligned accesses;
// otherwise the low address bits below the access size are ignored.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   i_req_valid / o_req_ready      - request handshake
//   i_req_write, i_req_size,
//   i_req_unsigned, i_req_addr,
//   i_req_wdata                    - request payload
//   o_rsp_valid / i_rsp_ready      - response handshake
//   o_rsp_rdata, o_rsp_err         - response payload
//   o_state                        - FSM state, for debug/checkers
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = $clog2(DEPTH) + $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output state_t            o_state
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = ADDR_W - LSB;
    localparam logic [IDX_W:0] DEPTH_V = (IDX_W+1)'(DEPTH);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_write;
    size_t       r_size;
    logic [2:0]  r_off;
    logic        r_uns;
    logic        r_err;
    logic        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic        r_rsp_err;

    size_t             w_size;
    logic [2:0]        w_off_raw;
    logic [2:0]        w_mask;
    logic [2:0]        w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_range_err;
    logic              w_size_err;
    logic              w_align_err;
    logic              w_err;
    logic              w_accept;
    logic [NB-1:0]     w_ram_we;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_ext;

    assign w_size    = size_t'(i_req_size);
    assign w_off_raw = 3'(i_req_addr[LSB-1:0]);
    assign w_mask    = size_mask(w_size);
    // Lane offset with sub-size bits dropped; only differs from w_off_raw
    // on a misaligned access.
    assign w_off     = w_off_raw & ~w_mask;
    assign w_idx     = i_req_addr[ADDR_W-1:LSB];

    assign w_range_err = ({1'b0, w_idx} >= DEPTH_V);
    assign w_size_err  = (w_size == SZ_D) && (DATA_W == 32);
`ifdef MISALIGN_TRAP_EN
    assign w_align_err = |(w_off_raw & w_mask);
`else
    assign w_align_err = 1'b0;
`endif
    assign w_err    = w_range_err | w_size_err | w_align_err;
    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

    // Stores commit at the acceptance edge; faulting accesses never write.
    assign w_ram_we    = (w_accept && i_req_write && !w_err) ? NB'(byte_en(w_size, w_off)) : '0;
    assign w_ram_addr  = w_range_err ? '0 : w_idx;
    assign w_ram_wdata = i_req_wdata << {w_off, 3'b000};

    dmem_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_ext = DATA_W'(load_extend(64'(w_ram_rdata), r_size, r_off, r_uns));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_write     <= 1'b0;
            r_size      <= SZ_B;
            r_off       <= 3'd0;
            r_uns       <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_write <= i_req_write;
                        r_size  <= w_size;
                        r_off   <= w_off;
                        r_uns   <= i_req_unsigned;
                        r_err   <= w_err;
                        // RAM pipeline output lines up with the final WAIT cycle.
                        r_cnt   <= i_req_write ? 2'd0 : 2'(READ_LAT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_rsp_rdata <= (r_write || r_err) ? '0 : w_ext;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl. Two instances share clk/rst:
//   dut 0: DATA_W=32, DEPTH=1024, READ_LAT=1
//   dut 1: DATA_W=32, DEPTH=1000, READ_LAT=3
// With DEPTH=1024 the 12-bit byte address cannot reach word 1024, so the
// out-of-range path is exercised on dut 1, whose first illegal word is 1000
// (byte 0xFA0) within the same 12-bit address space.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [11:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];
  state_t      st           [2];

  logic [32:0] exp_q[$];
  logic [7:0]  mdl [64];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_write(req_write[0]), .i_req_size(req_size[0]),
    .i_req_unsigned(req_unsigned[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]), .o_state(st[0])
  );

  dmem_ctrl #(.DATA_W(32), .DEPTH(1000), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_write(req_write[1]), .i_req_size(req_size[1]),
    .i_req_unsigned(req_unsigned[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]), .o_state(st[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access: push expectation, drive request, wait for the
  // response with a cycle budget, optionally stall it, then compare.
  task automatic access(input int sel, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
    int k;
    int exp_lat;
    logic [32:0] exp;
    logic [31:0] held;
    exp_lat = wr ? 1 : ((sel == 0) ? 1 : 3);
    check("req_ready_idle", 32'(req_ready[sel]), 32'd1);
    exp_q.push_back({exp_e, exp_d});
    req_valid[sel]    = 1'b1;
    req_write[sel]    = wr;
    req_size[sel]     = sz;
    req_unsigned[sel] = uns;
    req_addr[sel]     = addr;
    req_wdata[sel]    = wd;
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid[sel] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid[sel]) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles at addr 0x%03h", k, addr);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", 32'(k), 32'(exp_lat));
    held = rsp_rdata[sel];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[sel]), 32'd1);
      check("hold_rdata", rsp_rdata[sel], held);
      check("hold_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    exp = exp_q.pop_front();
    check("rdata", rsp_rdata[sel], exp[31:0]);
    check("err", 32'(rsp_err[sel]), 32'(exp[32]));
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
    @(negedge clk);
    check("retired", 32'(rsp_valid[sel]), 32'd0);
  endtask

  function automatic logic [31:0] mdl_load(input int a, input int sz, input logic uns);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a - 'h100 + i];
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    logic [31:0] wd;
    logic [31:0] mis_exp_d;
    logic        mis_exp_e;
    int a;
    int sz;
    int op;
    logic uns;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_size[i] = 2'd0;
      req_unsigned[i] = 1'b0;
      req_addr[i] = 12'd0;
      req_wdata[i] = 32'd0;
      rsp_ready[i] = 1'b0;
    end

    // Clock/reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_state", 32'(st[i]), 32'(ST_IDLE));
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Word store/load, READ_LAT=1
    access(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    access(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte/half extension
    access(0, 1'b1, 2'd2, 1'b0, 12'h020, 32'h80FF7F01, 32'h0, 1'b0, 0);
    access(0, 1'b0, 2'd0, 1'b0, 12'h023, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    access(0, 1'b0, 2'd0, 1'b1, 12'h023, 32'h0, 32'h00000080, 1'b0, 0);
    access(0, 1'b0, 2'd1, 1'b0, 12'h020, 32'h0, 32'h00007F01, 1'b0, 0);
    access(0, 1'b0, 2'd1, 1'b0, 12'h022, 32'h0, 32'hFFFF80FF, 1'b0, 0);
    access(0, 1'b0, 2'd1, 1'b1, 12'h022, 32'h0, 32'h000080FF, 1'b0, 0);

    // Partial stores preserve neighbouring bytes
    access(0, 1'b1, 2'd2, 1'b0, 12'h030, 32'h11223344, 32'h0, 1'b0, 0);
    access(0, 1'b1, 2'd0, 1'b0, 12'h031, 32'hFFFFFFAA, 32'h0, 1'b0, 0);
    access(0, 1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 32'h1122AA44, 1'b0, 0);
    access(0, 1'b1, 2'd1, 1'b0, 12'h032, 32'h12345566, 32'h0, 1'b0, 0);
    access(0, 1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 32'h5566AA44, 1'b0, 0);

    // Dword on a 32-bit memory faults with normal latency, no write
    access(0, 1'b0, 2'd3, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1, 0);
    access(0, 1'b1, 2'd3, 1'b0, 12'h010, 32'h01020304, 32'h0, 1'b1, 0);
    access(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    mis_exp_d = 32'h0;
    mis_exp_e = 1'b1;
`else
    mis_exp_d = 32'h80FF7F01;
    mis_exp_e = 1'b0;
`endif
    access(0, 1'b0, 2'd2, 1'b0, 12'h022, 32'h0, mis_exp_d, mis_exp_e, 0);

    // Randomized aligned traffic against a byte model, region 0x100..0x13F
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      for (int i = 0; i < 4; i++) mdl[4*w + i] = wd[8*i +: 8];
      access(0, 1'b1, 2'd2, 1'b0, 12'(32'h100 + 4*w), wd, 32'h0, 1'b0, 0);
    end
    for (int t = 0; t < 24; t++) begin
      op  = $urandom_range(0, 2);
      sz  = $urandom_range(0, 2);
      uns = 1'($urandom_range(0, 1));
      a   = 'h100 + ($urandom_range(0, 63) & ~((1 << sz) - 1));
      if (op == 0) begin
        wd = $urandom;
        for (int i = 0; i < (1 << sz); i++) mdl[a - 'h100 + i] = wd[8*i +: 8];
        access(0, 1'b1, 2'(sz), uns, 12'(a), wd, 32'h0, 1'b0, 0);
      end else begin
        access(0, 1'b0, 2'(sz), uns, 12'(a), 32'h0, mdl_load(a, sz, uns), 1'b0, 0);
      end
    end

    // READ_LAT=3 with 5 cycles of response backpressure
    access(1, 1'b1, 2'd2, 1'b0, 12'h040, 32'h0BADCAFE, 32'h0, 1'b0, 0);
    access(1, 1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 32'h0BADCAFE, 1'b0, 5);
    access(1, 1'b0, 2'd0, 1'b0, 12'h043, 32'h0, 32'h0000000B, 1'b0, 2);

    // Out-of-range store faults without touching RAM
    access(1, 1'b1, 2'd2, 1'b0, 12'h000, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    access(1, 1'b1, 2'd2, 1'b0, 12'hFA0, 32'h55555555, 32'h0, 1'b1, 0);
    access(1, 1'b0, 2'd2, 1'b0, 12'hFA4, 32'h0, 32'h0, 1'b1, 0);
    access(1, 1'b0, 2'd2, 1'b0, 12'h000, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Reset during WAIT discards the pending load
    check("pre_rst_ready", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0;
    req_addr[1] = 12'h040;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("in_wait_state", 32'(st[1]), 32'(ST_WAIT));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", 32'(st[1]), 32'(ST_IDLE));
    check("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    // RAM keeps its contents across reset
    access(1, 1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 32'h0BADCAFE, 1'b0, 0);
    access(0, 1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 32'h5566AA44, 1'b0, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
